// File: rtl/sel_skid_stage.sv
// sel_skid_stage: N-way word selector into a two-entry skid-buffered
// pipeline stage with valid/ready on both sides and synchronous flush.
module sel_skid_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        drop_cnt
);

    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             acc;
    logic             fire;
    logic             in_hs;
    logic [1:0]       drop_add;
    logic [CNT_W:0]   drop_sum;
    logic [CNT_W-1:0] drop_next;

    // Pick the candidate word; an out-of-range select yields zero.
    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(in_sel) == k) begin
                word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Ready depends only on registered state so there is no
    // combinational path from out_ready back to in_ready.
    assign in_ready  = !s_valid && !rst;
    assign in_hs     = in_valid && in_ready;
    assign acc       = in_hs && !flush;
    assign fire      = m_valid && out_ready;
    assign out_data  = m_data;
    assign out_valid = m_valid;

    // Count of valid words thrown away by a flush at this edge.
    always_comb begin
        drop_add  = {1'b0, m_valid && !out_ready}
                  + {1'b0, s_valid}
                  + {1'b0, in_hs};
        drop_sum  = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, drop_add};
        drop_next = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    // Main register: refill from skid first, else from the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (!m_valid || fire) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                m_data  <= s_data;
            end else if (acc) begin
                m_valid <= 1'b1;
                m_data  <= word;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Skid register: catches a word when the main register stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else if (flush) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else if (!m_valid || fire) begin
            s_valid <= 1'b0;
        end else if (acc) begin
            s_valid <= 1'b1;
            s_data  <= word;
        end
    end

    // Saturating tally of words discarded by flush; reset does not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= drop_next;
        end
    end

endmodule

// File: tb/tb_sel_skid_stage.sv
// tb_sel_skid_stage: scoreboard bench for sel_skid_stage.
// Accepted words are queued; outputs are compared against the queue head.
module tb_sel_skid_stage;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [CNT_W-1:0]        drop_cnt;

    int nvec  = 0;
    int nmiss = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] mdata = '0;
    int               mdrop = 0;
    logic             m_acc;

    sel_skid_stage #(
        .WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmiss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick(
        input logic [NUM_IN*WIDTH-1:0] d, input logic [SEL_W-1:0] s);
        logic [NUM_IN*WIDTH-1:0] t;
        t = d;
        case (s)
            2'd0: pick = t[31:0];
            2'd1: pick = t[63:32];
            2'd2: pick = t[95:64];
            default: pick = '0;
        endcase
    endfunction

    function automatic logic mready();
        return !rst && (q.size() < 2);
    endfunction

    // Check outputs at the falling edge, advance the model, then clock.
    task automatic step();
        logic mf;
        int   n;
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("out_data", out_data, mdata);
        chk("in_ready", {31'd0, in_ready}, {31'd0, mready()});
        chk("drop_cnt", {24'd0, drop_cnt}, mdrop);
        mf    = (q.size() > 0) && out_ready;
        m_acc = in_valid && mready() && !flush;
        if (rst) begin
            q.delete();
            mdata = '0;
            mdrop = 0;
            m_acc = 1'b0;
        end else if (flush) begin
            n = q.size() - (mf ? 1 : 0) + ((in_valid && mready()) ? 1 : 0);
            mdrop = (mdrop + n > 255) ? 255 : mdrop + n;
            q.delete();
            mdata = '0;
        end else begin
            if (mf) void'(q.pop_front());
            if (m_acc) q.push_back(pick(in_data, in_sel));
            if (q.size() > 0) mdata = q[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic fill_two();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_sel    = 2'd1;
        in_data   = {$urandom, $urandom, $urandom};
        step();
        in_data   = {$urandom, $urandom, $urandom};
        step();
    endtask

    initial begin
        rst = 1'b1;
        in_data = '0;
        in_sel = '0;
        idle();
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        step();

        // Stream three selects with out_ready high.
        in_data = {32'h33333333, 32'h22222222, 32'h11111111};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_sel = 2'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Out-of-range select still handshakes with a zero word.
        in_sel = 2'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();

        // Four words with out_ready low for two cycles.
        begin
            int idx = 0;
            for (int c = 0; c < 12; c++) begin
                out_ready = !(c == 2 || c == 3);
                in_valid = idx < 4;
                in_sel = 2'(idx % 3);
                in_data = {32'hA0000000 + idx, 32'hB0000000 + idx,
                           32'hC0000000 + idx};
                step();
                if (m_acc) idx++;
            end
            chk("bp_count", idx, 4);
        end
        idle();
        step();

        // Flush with main and skid full and input presented.
        fill_two();
        flush = 1'b1;
        in_valid = 1'b1;
        step();
        idle();
        step();
        in_valid = 1'b1;
        in_data = {32'h0, 32'h0, 32'h5A5A5A5A};
        in_sel = 2'd0;
        step();
        // Flush while main fires and a word is accepted.
        flush = 1'b1;
        step();
        idle();
        step();

        // Repeated flushes drive the counter into saturation.
        for (int r = 0; r < 140; r++) begin
            fill_two();
            flush = 1'b1;
            in_valid = 1'b1;
            step();
            idle();
        end
        step();
        chk("drop_sat", {24'd0, drop_cnt}, 32'd255);

        // Reset in the middle of a transfer.
        fill_two();
        rst = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("rst_data", out_data, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
